cgra_pc_sequencer: RTL and testbench
====================================

// Module: cgra_pc_sequencer
// PURPOSE
//  Registered program-counter sequencer for one CGRA processing element.
//  Owns the PC register, an internal vector-element counter (no external done_auto_incr),
//  and scalar branch resolution (BNE/BEQ/JMP). Adds start/halt/abort control.
//  Sits between instruction memory (drives pc) and decode (supplies instr_* fields).
// PARAMETERS
//  PC_W      12    PC and branch-target width; PC arithmetic is modulo 2**PC_W
//  VLEN_W    8     vector-length / element-index width
//  RESET_PC  0     PC value loaded at reset, on start and on abort
// PORTS
//  axis_aclk      in   1       clock
//  axis_resetn    in   1       asynchronous active-low reset
//  start          in   1       1-cycle pulse: leave IDLE/HALT, begin fetching at RESET_PC
//  abort          in   1       synchronous: return to IDLE, pc<=RESET_PC
//  stall          in   1       freeze pc, vect_idx and state this cycle
//  instr_valid    in   1       decode fields below are valid this cycle
//  instr_is_vect  in   1       current instruction is a vector op
//  instr_vlen     in   VLEN_W  element count of the vector op (0 treated as 1)
//  instr_br_op    in   2       00 none, 01 BNE, 10 BEQ, 11 JMP
//  instr_halt     in   1       halt instruction
//  flag_eq        in   1       comparator result for BNE/BEQ
//  br_target      in   PC_W    absolute branch target
//  pc             out  PC_W    current fetch address (registered)
//  vect_idx       out  VLEN_W  current element index (registered)
//  vect_last      out  1       comb: RUN, not stall, instr_valid & instr_is_vect & vlen<=1; or VECT & vect_idx==eff_vlen-1
//  busy           out  1       state is RUN or VECT
//  halted         out  1       state is HALT
//  br_taken       out  1       registered 1-cycle pulse: a branch loaded pc last cycle
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, vect_idx=0, br_taken=0, busy=0, halted=0.
//  States IDLE, RUN, VECT, HALT; all registers update on rising axis_aclk.
//  Priority each cycle: abort > stall > start > instruction processing.
//  abort (any state): next IDLE, pc=RESET_PC, vect_idx=0, br_taken=0.
//  stall (no abort): all registers hold; br_taken forced 0.
//  IDLE/HALT + start: pc=RESET_PC, vect_idx=0, next RUN. start ignored in RUN/VECT.
//  RUN, instr_valid=0: hold (bubble).
//  RUN, instr_halt: next HALT, pc holds (halt wins over vect/branch fields).
//  RUN, vector, eff_vlen=max(instr_vlen,1):
//   eff_vlen==1 -> pc=pc+1, vect_idx=0, stay RUN.
//   eff_vlen>1 -> vect_idx=1, pc holds, next VECT.
//   instr_br_op ignored on vector instructions.
//  RUN, scalar: taken = (BNE & !flag_eq) | (BEQ & flag_eq) | JMP.
//   taken -> pc=br_target, br_taken=1 next cycle; else pc=pc+1.
//  VECT (instr fields held stable by decode; sequencer ignores instr_valid here):
//   vect_idx<eff_vlen-1 -> vect_idx+1; vect_idx==eff_vlen-1 -> vect_idx=0, pc=pc+1, next RUN.
//   Exactly eff_vlen cycles (excl. stalls) per vector instruction, PC advances once.
//  Wrap: pc=2**PC_W-1 increments to 0; no overflow flag.
//  Max vlen 2**VLEN_W-1; index never exceeds eff_vlen-1.
//  Reset asserted mid-VECT: immediate return to reset values, no pending increment.
// TESTING
//  1 reset, start -> pc=0, busy=1; 3 valid scalar no-branch instr -> pc 1,2,3; br_taken=0.
//  2 pc=5, BNE flag_eq=0 target=0x020 -> pc=0x020, br_taken=1 one cycle; BNE flag_eq=1 -> pc=6.
//  3 vector vlen=4 at pc=8 -> vect_idx 1,2,3,0 over 4 cycles, vect_last on 4th, pc=9 after.
//  4 vlen=0 and vlen=1 at pc=3 -> pc=4 next cycle, never enters VECT; stall 2 cycles mid-vlen=4 -> total 6 cycles.
//  5 pc=0xFFF (PC_W=12) scalar -> pc=0x000; halt -> halted=1, pc holds; start -> pc=0, RUN.
//  6 abort during VECT (vect_idx=2) -> IDLE, pc=0, vect_idx=0; axis_resetn low mid-run -> reset values async.

Source files
------------

// File: rtl/cgra_pc_sequencer_if.sv
// Sequencer-facing bundle: control pulses, decode fields and the sequencer's
// registered PC/element outputs. master = controller/decode side, slave = sequencer.
interface cgra_pc_sequencer_if #(
    parameter int PC_W   = 12,
    parameter int VLEN_W = 8
);
    logic              start;
    logic              abort;
    logic              stall;
    logic              instr_valid;
    logic              instr_is_vect;
    logic [VLEN_W-1:0] instr_vlen;
    logic [1:0]        instr_br_op;
    logic              instr_halt;
    logic              flag_eq;
    logic [PC_W-1:0]   br_target;
    logic [PC_W-1:0]   pc;
    logic [VLEN_W-1:0] vect_idx;
    logic              vect_last;
    logic              busy;
    logic              halted;
    logic              br_taken;

    modport master (
        output start, abort, stall, instr_valid, instr_is_vect, instr_vlen,
               instr_br_op, instr_halt, flag_eq, br_target,
        input  pc, vect_idx, vect_last, busy, halted, br_taken
    );

    modport slave (
        input  start, abort, stall, instr_valid, instr_is_vect, instr_vlen,
               instr_br_op, instr_halt, flag_eq, br_target,
        output pc, vect_idx, vect_last, busy, halted, br_taken
    );
endinterface

// File: rtl/cgra_pc_sequencer.sv
// Program-counter sequencer for one CGRA PE: owns PC, vector element index and
// scalar branch resolution, with start/halt/abort/stall control.
module cgra_pc_sequencer #(
    parameter int              PC_W     = 12,
    parameter int              VLEN_W   = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                 axis_aclk,
    input  logic                 axis_resetn,
    cgra_pc_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        VECT = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [1:0]        BR_BNE = 2'b01;
    localparam logic [1:0]        BR_BEQ = 2'b10;
    localparam logic [1:0]        BR_JMP = 2'b11;
    localparam logic [VLEN_W-1:0] V_ONE  = {{(VLEN_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]   P_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    state_t            state_p0, state_nxt;
    logic [PC_W-1:0]   pc_p0, pc_nxt;
    logic [VLEN_W-1:0] vect_idx_p0, vect_idx_nxt;
    logic              br_taken_p0, br_taken_nxt;
    logic [VLEN_W-1:0] eff_vlen;
    logic [VLEN_W-1:0] idx_last;
    logic              br_cond;

    // A zero-length vector op still occupies one element slot.
    function automatic logic [VLEN_W-1:0] clamp_vlen(input logic [VLEN_W-1:0] vlen);
        return (vlen == '0) ? V_ONE : vlen;
    endfunction

    assign eff_vlen = clamp_vlen(bus.instr_vlen);
    assign idx_last = eff_vlen - V_ONE;

    always_comb begin
        br_cond = 1'b0;
        case (bus.instr_br_op)
            BR_BNE:  br_cond = !bus.flag_eq;
            BR_BEQ:  br_cond = bus.flag_eq;
            BR_JMP:  br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt    = state_p0;
        pc_nxt       = pc_p0;
        vect_idx_nxt = vect_idx_p0;
        br_taken_nxt = 1'b0;
        if (bus.abort) begin
            state_nxt    = IDLE;
            pc_nxt       = RESET_PC;
            vect_idx_nxt = '0;
        end else if (!bus.stall) begin
            case (state_p0)
                IDLE, HALT: begin
                    if (bus.start) begin
                        state_nxt    = RUN;
                        pc_nxt       = RESET_PC;
                        vect_idx_nxt = '0;
                    end
                end
                RUN: begin
                    if (bus.instr_valid) begin
                        if (bus.instr_halt) begin
                            state_nxt = HALT;
                        end else if (bus.instr_is_vect) begin
                            if (eff_vlen == V_ONE) begin
                                pc_nxt       = pc_p0 + P_ONE;
                                vect_idx_nxt = '0;
                            end else begin
                                vect_idx_nxt = V_ONE;
                                state_nxt    = VECT;
                            end
                        end else if (br_cond) begin
                            pc_nxt       = bus.br_target;
                            br_taken_nxt = 1'b1;
                        end else begin
                            pc_nxt = pc_p0 + P_ONE;
                        end
                    end
                end
                VECT: begin
                    // Decode holds the vector fields stable, so instr_valid is not consulted.
                    if (vect_idx_p0 == idx_last) begin
                        vect_idx_nxt = '0;
                        pc_nxt       = pc_p0 + P_ONE;
                        state_nxt    = RUN;
                    end else begin
                        vect_idx_nxt = vect_idx_p0 + V_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Stage p0: architectural sequencer registers
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_p0    <= IDLE;
            pc_p0       <= RESET_PC;
            vect_idx_p0 <= '0;
            br_taken_p0 <= 1'b0;
        end else begin
            state_p0    <= state_nxt;
            pc_p0       <= pc_nxt;
            vect_idx_p0 <= vect_idx_nxt;
            br_taken_p0 <= br_taken_nxt;
        end
    end

    assign bus.pc        = pc_p0;
    assign bus.vect_idx  = vect_idx_p0;
    assign bus.busy      = (state_p0 == RUN) || (state_p0 == VECT);
    assign bus.halted    = (state_p0 == HALT);
    assign bus.br_taken  = br_taken_p0;
    assign bus.vect_last = ((state_p0 == RUN) && !bus.stall && bus.instr_valid &&
                            bus.instr_is_vect && (bus.instr_vlen <= V_ONE)) ||
                           ((state_p0 == VECT) && (vect_idx_p0 == idx_last));

endmodule

// File: tb/tb_cgra_pc_sequencer.sv
// Directed bench for cgra_pc_sequencer: each driven cycle queues its expected
// outcome, a monitor pops and compares after every rising edge.
module tb_cgra_pc_sequencer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cgra_pc_sequencer_if #(.PC_W(12), .VLEN_W(8)) bus ();

    cgra_pc_sequencer #(.PC_W(12), .VLEN_W(8), .RESET_PC(12'h000)) dut (
        .axis_aclk   (clk),
        .axis_resetn (resetn),
        .bus         (bus)
    );

    typedef struct {
        string       nm;
        logic [11:0] pc;
        logic [7:0]  idx;
        logic [2:0]  fl;   // {busy, halted, br_taken} after the edge
        logic        vl;   // vect_last during the cycle
    } exp_t;

    exp_t sbq[$];

    // ctl = {start, abort, stall}; inputs applied at negedge, expectation queued
    task automatic cyc(input string nm, input logic [2:0] ctl, input logic v,
                       input logic isv, input logic [7:0] vlen, input logic [1:0] br,
                       input logic hlt, input logic feq, input logic [11:0] tgt,
                       input logic [11:0] epc, input logic [7:0] eidx,
                       input logic [2:0] efl, input logic evl);
        exp_t e;
        @(negedge clk);
        {bus.start, bus.abort, bus.stall} = ctl;
        bus.instr_valid   = v;
        bus.instr_is_vect = isv;
        bus.instr_vlen    = vlen;
        bus.instr_br_op   = br;
        bus.instr_halt    = hlt;
        bus.flag_eq       = feq;
        bus.br_target     = tgt;
        e.nm  = nm;
        e.pc  = epc;
        e.idx = eidx;
        e.fl  = efl;
        e.vl  = evl;
        sbq.push_back(e);
    endtask

    // Monitor: vect_last sampled just before the edge, registers just after it
    initial begin : monitor
        logic        vl_s;
        exp_t        e;
        logic [23:0] act;
        logic [23:0] want;
        forever begin
            @(negedge clk);
            #4;
            vl_s = bus.vect_last;
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                act  = {bus.pc, bus.vect_idx, bus.busy, bus.halted, bus.br_taken, vl_s};
                want = {e.pc, e.idx, e.fl, e.vl};
                if (act !== want) begin
                    errors++;
                    $display("FAIL %s: got pc=%h idx=%0d busy/halted/br=%b vlast=%b, want pc=%h idx=%0d busy/halted/br=%b vlast=%b",
                             e.nm, bus.pc, bus.vect_idx, {bus.busy, bus.halted, bus.br_taken}, vl_s,
                             e.pc, e.idx, e.fl, e.vl);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        {bus.start, bus.abort, bus.stall} = 3'b000;
        bus.instr_valid   = 1'b0;
        bus.instr_is_vect = 1'b0;
        bus.instr_vlen    = 8'd0;
        bus.instr_br_op   = 2'b00;
        bus.instr_halt    = 1'b0;
        bus.flag_eq       = 1'b0;
        bus.br_target     = 12'h000;
        repeat (2) @(negedge clk);

        cyc("reset",          3'b000, 0,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b000,0);
        @(negedge clk);
        resetn = 1'b1;

        // Start and plain scalar flow
        cyc("idle_hold",      3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b000,0);
        cyc("start",          3'b100, 0,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b100,0);
        cyc("scalar_1",       3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h001,8'd0,3'b100,0);
        cyc("scalar_2",       3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h002,8'd0,3'b100,0);
        cyc("scalar_3",       3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h003,8'd0,3'b100,0);
        cyc("bubble",         3'b000, 0,0,8'd0,2'b00,0,0,12'h000, 12'h003,8'd0,3'b100,0);

        // Branch resolution
        cyc("jmp_5",          3'b000, 1,0,8'd0,2'b11,0,0,12'h005, 12'h005,8'd0,3'b101,0);
        cyc("bne_taken",      3'b000, 1,0,8'd0,2'b01,0,0,12'h020, 12'h020,8'd0,3'b101,0);
        cyc("br_pulse_end",   3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h021,8'd0,3'b100,0);
        cyc("jmp_5b",         3'b000, 1,0,8'd0,2'b11,0,0,12'h005, 12'h005,8'd0,3'b101,0);
        cyc("bne_not_taken",  3'b000, 1,0,8'd0,2'b01,0,1,12'h020, 12'h006,8'd0,3'b100,0);
        cyc("beq_not_taken",  3'b000, 1,0,8'd0,2'b10,0,0,12'h040, 12'h007,8'd0,3'b100,0);
        cyc("beq_taken",      3'b000, 1,0,8'd0,2'b10,0,1,12'h008, 12'h008,8'd0,3'b101,0);

        // vlen=4 at pc=8, branch fields ignored, instr_valid ignored in VECT
        cyc("vec4_c1",        3'b000, 1,1,8'd4,2'b11,0,0,12'h077, 12'h008,8'd1,3'b100,0);
        cyc("vec4_c2",        3'b000, 0,1,8'd4,2'b11,0,0,12'h077, 12'h008,8'd2,3'b100,0);
        cyc("vec4_c3",        3'b000, 0,1,8'd4,2'b11,0,0,12'h077, 12'h008,8'd3,3'b100,0);
        cyc("vec4_c4",        3'b000, 0,1,8'd4,2'b11,0,0,12'h077, 12'h009,8'd0,3'b100,1);

        // Degenerate lengths stay in RUN
        cyc("vlen0",          3'b000, 1,1,8'd0,2'b00,0,0,12'h000, 12'h00A,8'd0,3'b100,1);
        cyc("vlen1",          3'b000, 1,1,8'd1,2'b00,0,0,12'h000, 12'h00B,8'd0,3'b100,1);
        cyc("after_vlen1",    3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h00C,8'd0,3'b100,0);

        // Stall twice inside vlen=4: six cycles in total
        cyc("stv_c1",         3'b000, 1,1,8'd4,2'b00,0,0,12'h000, 12'h00C,8'd1,3'b100,0);
        cyc("stv_stall1",     3'b001, 1,1,8'd4,2'b00,0,0,12'h000, 12'h00C,8'd1,3'b100,0);
        cyc("stv_stall2",     3'b001, 1,1,8'd4,2'b00,0,0,12'h000, 12'h00C,8'd1,3'b100,0);
        cyc("stv_c2",         3'b000, 1,1,8'd4,2'b00,0,0,12'h000, 12'h00C,8'd2,3'b100,0);
        cyc("stv_c3",         3'b000, 1,1,8'd4,2'b00,0,0,12'h000, 12'h00C,8'd3,3'b100,0);
        cyc("stv_c4",         3'b000, 1,1,8'd4,2'b00,0,0,12'h000, 12'h00D,8'd0,3'b100,1);

        // Stall after a taken branch, then PC wrap
        cyc("jmp_fff",        3'b000, 1,0,8'd0,2'b11,0,0,12'hFFF, 12'hFFF,8'd0,3'b101,0);
        cyc("stall_after_br", 3'b001, 1,0,8'd0,2'b11,0,0,12'h123, 12'hFFF,8'd0,3'b100,0);
        cyc("wrap",           3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b100,0);
        cyc("scalar_pre_halt",3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h001,8'd0,3'b100,0);

        // Halt (wins over vector/branch fields), restart
        cyc("halt",           3'b000, 1,1,8'd4,2'b11,1,0,12'h123, 12'h001,8'd0,3'b010,0);
        cyc("halt_hold",      3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h001,8'd0,3'b010,0);
        cyc("restart",        3'b100, 0,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b100,0);
        cyc("start_in_run",   3'b100, 1,0,8'd0,2'b00,0,0,12'h000, 12'h001,8'd0,3'b100,0);

        // Abort mid-vector and abort priority
        cyc("abv_c1",         3'b000, 1,1,8'd4,2'b00,0,0,12'h000, 12'h001,8'd1,3'b100,0);
        cyc("abv_c2",         3'b000, 1,1,8'd4,2'b00,0,0,12'h000, 12'h001,8'd2,3'b100,0);
        cyc("abort_vect",     3'b010, 1,1,8'd4,2'b00,0,0,12'h000, 12'h000,8'd0,3'b000,0);
        cyc("idle_after_ab",  3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b000,0);
        cyc("start2",         3'b100, 0,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b100,0);
        cyc("scalar_a",       3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h001,8'd0,3'b100,0);
        cyc("abort_priority", 3'b111, 1,0,8'd0,2'b11,0,0,12'h055, 12'h000,8'd0,3'b000,0);

        // Asynchronous reset mid-vector
        cyc("start3",         3'b100, 0,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b100,0);
        cyc("scalar_b1",      3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h001,8'd0,3'b100,0);
        cyc("scalar_b2",      3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h002,8'd0,3'b100,0);
        cyc("scalar_b3",      3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h003,8'd0,3'b100,0);
        cyc("rv_c1",          3'b000, 1,1,8'd4,2'b00,0,0,12'h000, 12'h003,8'd1,3'b100,0);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.pc, bus.vect_idx, bus.busy, bus.halted, bus.br_taken} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h idx=%0d busy/halted/br=%b, want pc=000 idx=0 busy/halted/br=000",
                     bus.pc, bus.vect_idx, {bus.busy, bus.halted, bus.br_taken});
        end
        cyc("reset_hold",     3'b000, 0,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b000,0);
        @(negedge clk);
        resetn = 1'b1;
        cyc("start_post_rst", 3'b100, 0,0,8'd0,2'b00,0,0,12'h000, 12'h000,8'd0,3'b100,0);
        cyc("scalar_post_rst",3'b000, 1,0,8'd0,2'b00,0,0,12'h000, 12'h001,8'd0,3'b100,0);

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expectations left in queue, want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
